// File: rtl/player_motion_ctrl_if.sv
// Bundle between the button/collision front end and the motion controller.
// master: drives tick, buttons and flags; slave: returns velocities and status.
interface player_motion_ctrl_if #(
    parameter int CW = 5
);
    logic              frame_tick;
    logic              left;
    logic              right;
    logic              jump;
    logic              on_ground;
    logic              hit_wall;
    logic signed [7:0] vel_x;
    logic signed [7:0] vel_y;
    logic [2:0]        state;
    logic [CW-1:0]     charge;
    logic              face_dir;
    logic              launch;

    modport master (
        output frame_tick, left, right, jump, on_ground, hit_wall,
        input  vel_x, vel_y, state, charge, face_dir, launch
    );

    modport slave (
        input  frame_tick, left, right, jump, on_ground, hit_wall,
        output vel_x, vel_y, state, charge, face_dir, launch
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Frame-stepped player motion controller: walk, hold-to-charge jump, airborne physics.
// Ports: sys_clk, sys_rst (sync, active-high), mc (slave side of player_motion_ctrl_if).
module player_motion_ctrl #(
    parameter int CHARGE_MAX = 31,
    parameter int VX_WALK    = 2,
    parameter int VX_JUMP    = 3,
    parameter int VY_BASE    = 4,
    parameter int GRAVITY    = 1,
    parameter int VY_TERM    = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    player_motion_ctrl_if.slave mc
);
    localparam int CW = $clog2(CHARGE_MAX + 1);

    localparam logic [CW-1:0]      CMAX   = CW'(CHARGE_MAX);
    localparam logic signed [7:0]  VXW    = 8'(VX_WALK);
    localparam logic signed [7:0]  VXJ    = 8'(VX_JUMP);
    localparam logic [7:0]         VYB    = 8'(VY_BASE);
    localparam logic signed [8:0]  GRAV9  = 9'(GRAVITY);
    localparam logic signed [8:0]  TERM9  = 9'(VY_TERM);
    localparam logic signed [7:0]  TERM8  = 8'(VY_TERM);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WALK   = 3'd1,
        S_CHARGE = 3'd2,
        S_AIR    = 3'd3,
        S_LAND   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic signed [7:0] vel_x_q, vel_x_d;
    logic signed [7:0] vel_y_q, vel_y_d;
    logic [CW-1:0]     charge_q, charge_d;
    logic              face_q, face_d;
    logic              launch_q, launch_d;

    logic              dir_w;
    logic signed [8:0] vy_ext_w;
    logic signed [8:0] vy_grav_w;
    logic signed [7:0] vy_fall_w;
    logic [7:0]        lift_w;
    logic signed [7:0] vy_launch_w;
    logic [CW-1:0]     charge_inc_w;

    // Both buttons together cancel out.
    assign dir_w = mc.left ^ mc.right;

    // Gravity step, clamped at terminal velocity (9 bits avoids wrap).
    assign vy_ext_w  = {vel_y_q[7], vel_y_q};
    assign vy_grav_w = vy_ext_w + GRAV9;
    assign vy_fall_w = (vy_grav_w > TERM9) ? TERM8 : vy_grav_w[7:0];

    assign lift_w      = VYB + 8'(charge_q);
    assign vy_launch_w = 8'd0 - lift_w;

    assign charge_inc_w = (charge_q == CMAX) ? charge_q : charge_q + CW'(1);

    // State and datapath registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            vel_x_q  <= '0;
            vel_y_q  <= '0;
            charge_q <= '0;
            face_q   <= 1'b1;
            launch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vel_x_q  <= vel_x_d;
            vel_y_q  <= vel_y_d;
            charge_q <= charge_d;
            face_q   <= face_d;
            launch_q <= launch_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (mc.frame_tick) begin
            unique case (state_q)
                S_IDLE, S_WALK: begin
                    if (!mc.on_ground)   state_d = S_AIR;
                    else if (mc.jump)    state_d = S_CHARGE;
                    else if (dir_w)      state_d = S_WALK;
                    else                 state_d = S_IDLE;
                end
                S_CHARGE: begin
                    if (!mc.on_ground || !mc.jump) state_d = S_AIR;
                end
                S_AIR: begin
                    // Land only when moving down or at rest.
                    if (mc.on_ground && !vel_y_q[7]) state_d = S_LAND;
                end
                S_LAND:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath / output logic.
    always_comb begin
        vel_x_d  = vel_x_q;
        vel_y_d  = vel_y_q;
        charge_d = charge_q;
        face_d   = face_q;
        launch_d = 1'b0;
        if (mc.frame_tick) begin
            unique case (state_q)
                S_IDLE, S_WALK: begin
                    if (!mc.on_ground) begin
                        vel_x_d = '0;
                        vel_y_d = '0;
                    end else if (mc.jump) begin
                        vel_x_d  = '0;
                        charge_d = '0;
                    end else if (dir_w) begin
                        vel_x_d = mc.right ? VXW : -VXW;
                        face_d  = mc.right;
                    end else begin
                        vel_x_d = '0;
                    end
                end
                S_CHARGE: begin
                    vel_x_d = '0;
                    if (!mc.on_ground) begin
                        charge_d = '0;
                        vel_y_d  = '0;
                    end else if (mc.jump) begin
                        charge_d = charge_inc_w;
                        if (dir_w) face_d = mc.right;
                    end else begin
                        vel_y_d  = vy_launch_w;
                        vel_x_d  = !dir_w   ? 8'sd0 :
                                   mc.right ? VXJ   : -VXJ;
                        launch_d = 1'b1;
                        charge_d = '0;
                    end
                end
                S_AIR: begin
                    if (mc.on_ground && !vel_y_q[7]) begin
                        vel_x_d = '0;
                        vel_y_d = '0;
                    end else begin
                        vel_y_d = vy_fall_w;
                        if (mc.hit_wall && vel_x_q != 8'sd0) begin
                            vel_x_d = 8'sd0 - vel_x_q;
                            face_d  = ~face_q;
                        end
                    end
                end
                S_LAND: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign mc.vel_x    = vel_x_q;
    assign mc.vel_y    = vel_y_q;
    assign mc.state    = state_q;
    assign mc.charge   = charge_q;
    assign mc.face_dir = face_q;
    assign mc.launch   = launch_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl.
// Stimulus pushes expected snapshots; a monitor pops them after each update.
module tb_player_motion_ctrl;
    localparam logic [2:0] IDLE = 3'd0, WALK = 3'd1, CHRG = 3'd2,
                           AIR = 3'd3, LAND = 3'd4;

    typedef struct packed {
        logic [2:0]        st;
        logic signed [7:0] vx;
        logic signed [7:0] vy;
        logic [4:0]        ch;
        logic              fd;
        logic              la;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    player_motion_ctrl_if #(.CW(5)) bus ();

    player_motion_ctrl dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .mc      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic pend     = 1'b0;
    logic prev_la  = 1'b0;

    always @(posedge sys_clk) pend <= bus.frame_tick | sys_rst;

    always @(negedge sys_clk) begin
        exp_t e, g;
        if (prev_la) begin
            checks++;
            if (bus.launch !== 1'b0) begin
                failures++;
                $display("FAIL launch_width: launch=%b required 0", bus.launch);
            end
        end
        prev_la = pend && (bus.launch === 1'b1);
        if (pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: update seen with no expectation");
            end else begin
                e = exp_q.pop_front();
                g = '{bus.state, bus.vel_x, bus.vel_y, bus.charge,
                      bus.face_dir, bus.launch};
                if (g !== e) begin
                    failures++;
                    $display("FAIL step%0d: got st=%0d vx=%0d vy=%0d ch=%0d fd=%b la=%b required st=%0d vx=%0d vy=%0d ch=%0d fd=%b la=%b",
                             checks, g.st, g.vx, g.vy, g.ch, g.fd, g.la,
                             e.st, e.vx, e.vy, e.ch, e.fd, e.la);
                end
            end
        end
    end

    task automatic step(input logic l, r, j, g, w,
                        input logic [2:0] st, input int vx, vy, ch,
                        input logic fd, la);
        exp_t e;
        @(negedge sys_clk);
        bus.left = l; bus.right = r; bus.jump = j;
        bus.on_ground = g; bus.hit_wall = w;
        bus.frame_tick = 1'b1;
        e = '{st, 8'(vx), 8'(vy), 5'(ch), fd, la};
        exp_q.push_back(e);
        @(negedge sys_clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic do_reset(input logic tick, j);
        exp_t e;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        bus.frame_tick = tick;
        bus.jump = j;
        e = '{IDLE, 8'sd0, 8'sd0, 5'd0, 1'b1, 1'b0};
        exp_q.push_back(e);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.frame_tick = 0; bus.left = 0; bus.right = 0;
        bus.jump = 0; bus.on_ground = 1; bus.hit_wall = 0;
        repeat (2) @(negedge sys_clk);
        do_reset(1'b0, 1'b0);

        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 1, 0, WALK, 2, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0, IDLE, 0, 0, 0, 1, 0);

        step(0, 0, 1, 1, 0, CHRG, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 10; i++)
            step(0, 0, 1, 1, 0, CHRG, 0, 0, i, 1, 0);
        step(0, 1, 0, 1, 0, AIR, 3, -14, 0, 1, 1);

        step(0, 0, 0, 0, 1, AIR, -3, -13, 0, 0, 0);
        step(0, 0, 0, 1, 0, AIR, -3, -12, 0, 0, 0);
        for (int k = 1; k <= 25; k++)
            step(0, 0, 0, 0, 0, AIR, -3, (k > 20) ? 8 : -12 + k, 0, 0, 0);
        step(1, 0, 1, 1, 1, LAND, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, IDLE, 0, 0, 0, 0, 0);

        @(negedge sys_clk); bus.jump = 1'b1;
        @(negedge sys_clk); bus.jump = 1'b0;
        step(0, 0, 0, 1, 0, IDLE, 0, 0, 0, 0, 0);

        step(0, 0, 1, 1, 0, CHRG, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 40; i++)
            step(0, 0, 1, 1, 0, CHRG, 0, 0, (i > 31) ? 31 : i, 0, 0);
        step(1, 1, 0, 1, 0, AIR, 0, -35, 0, 0, 1);
        step(0, 0, 0, 0, 1, AIR, 0, -34, 0, 0, 0);

        do_reset(1'b0, 1'b0);
        step(0, 0, 1, 1, 0, CHRG, 0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0, CHRG, 0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0, CHRG, 0, 0, 2, 1, 0);
        do_reset(1'b1, 1'b0);

        step(1, 0, 0, 1, 0, WALK, -2, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, AIR, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, LAND, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, IDLE, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, CHRG, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, CHRG, 0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0, AIR, 0, 0, 0, 1, 0);

        repeat (3) @(negedge sys_clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0",
                     exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
